// File: rtl/jb_ul_oran_request_dispatch.sv
// ---------------------------------------------------------------------------
// jb_ul_oran_request_dispatch
//
// Consumer side of the UL O-RAN request FIFO. Each 24-bit request word is
// popped, range-checked and expanded into one or more PRB-burst command
// beats for the UL IQ fetch engine.
//
// Request word layout: [23:21] port, [20:17] symbol, [16:8] start_prb,
//                      [7:0] num_prb.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   fifo_read          pop strobe to the FIFO (combinational)
//   fifo_read_data     FIFO head word, valid in the same cycle as fifo_read
//   fifo_empty         FIFO empty flag (registered inside the FIFO)
//   cmd_valid/ready    command handshake. cmd_valid rises when a beat is
//                      available; a beat transfers on a clock edge where
//                      cmd_valid & cmd_ready. While cmd_valid & ~cmd_ready
//                      every cmd_* field holds, and cmd_valid never drops
//                      without a transfer.
//   cmd_port/symbol    antenna port and symbol index of the request
//   cmd_prb/len/last   first PRB, PRB count (1..MAX_BURST) and final-beat flag
//   busy               FSM state: 0 = IDLE, 1 = ISSUE (two-state FSM)
//   err_range          one-cycle pulse when a popped request is dropped
//   req_count          accepted requests (statistics build only, else 0)
//   cmd_count          transferred beats (statistics build only, else 0)
//
// Build option: define UL_ORAN_DISPATCH_STATS_EN to build the saturating
// req_count/cmd_count counters. Without it both outputs are tied to zero.
// ---------------------------------------------------------------------------
module jb_ul_oran_request_dispatch #(
  parameter int MAX_BURST = 16,
  parameter int PRB_LIMIT = 273,
  parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fifo_read,
  input  logic [23:0]      fifo_read_data,
  input  logic             fifo_empty,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_port,
  output logic [3:0]       cmd_symbol,
  output logic [8:0]       cmd_prb,
  output logic [LEN_W-1:0] cmd_len,
  output logic             cmd_last,
  output logic             busy,
  output logic             err_range,
  output logic [15:0]      req_count,
  output logic [15:0]      cmd_count
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  localparam logic [8:0] BURST_9  = 9'(MAX_BURST);
  localparam logic [9:0] LIMIT_10 = 10'(PRB_LIMIT);

  logic [0:0] state;
  logic [7:0] remaining;   // PRBs still to issue, including the current beat
  logic [7:0] next_rem;
  logic       hs;
  logic       pop;

  // Head-word decode
  logic [2:0] req_port;
  logic [3:0] req_sym;
  logic [8:0] req_start;
  logic [7:0] req_num;
  logic [9:0] req_end;
  logic       req_ok;

  assign {req_port, req_sym, req_start, req_num} = fifo_read_data;

  // 10-bit sum: start (max 511) + num (max 255) cannot wrap.
  assign req_end = {1'b0, req_start} + {2'b00, req_num};
  assign req_ok  = (req_num != 8'd0) && (req_sym <= 4'd13) && (req_end <= LIMIT_10);

  assign hs  = cmd_valid & cmd_ready;

  // Pop from IDLE, or on the final beat's transfer so requests run back to
  // back. Only one request is ever in flight.
  assign fifo_read = ~fifo_empty & ((state == S_IDLE) | (hs & cmd_last));
  assign pop       = fifo_read;
  assign busy      = (state != S_IDLE);

  assign next_rem = remaining - 8'(cmd_len);

  // Beat length for a given number of outstanding PRBs.
  function automatic logic [LEN_W-1:0] beat_len(input logic [7:0] rem);
    if ({1'b0, rem} > BURST_9) begin
      return LEN_W'(MAX_BURST);
    end else begin
      return LEN_W'(rem);
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cmd_valid  <= 1'b0;
      cmd_port   <= '0;
      cmd_symbol <= '0;
      cmd_prb    <= '0;
      cmd_len    <= '0;
      cmd_last   <= 1'b0;
      remaining  <= '0;
      err_range  <= 1'b0;
    end else begin
      err_range <= 1'b0;
      if (pop) begin
        // Covers both the pop from IDLE and the pop on a final-beat transfer.
        if (req_ok) begin
          state      <= S_ISSUE;
          cmd_valid  <= 1'b1;
          cmd_port   <= req_port;
          cmd_symbol <= req_sym;
          cmd_prb    <= req_start;
          remaining  <= req_num;
          cmd_len    <= beat_len(req_num);
          cmd_last   <= ({1'b0, req_num} <= BURST_9);
        end else begin
          state     <= S_IDLE;
          cmd_valid <= 1'b0;
          err_range <= 1'b1;
        end
      end else if (hs) begin
        if (cmd_last) begin
          state     <= S_IDLE;
          cmd_valid <= 1'b0;
        end else begin
          // The next beat starts below start+num <= PRB_LIMIT, so 9 bits hold it.
          cmd_prb   <= cmd_prb + 9'(cmd_len);
          remaining <= next_rem;
          cmd_len   <= beat_len(next_rem);
          cmd_last  <= ({1'b0, next_rem} <= BURST_9);
        end
      end
    end
  end

`ifdef UL_ORAN_DISPATCH_STATS_EN
  logic [15:0] req_cnt_q;
  logic [15:0] cmd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt_q <= '0;
      cmd_cnt_q <= '0;
    end else begin
      if (pop && req_ok && (req_cnt_q != 16'hFFFF)) begin
        req_cnt_q <= req_cnt_q + 16'd1;
      end
      if (hs && (cmd_cnt_q != 16'hFFFF)) begin
        cmd_cnt_q <= cmd_cnt_q + 16'd1;
      end
    end
  end

  assign req_count = req_cnt_q;
  assign cmd_count = cmd_cnt_q;
`else
  assign req_count = 16'd0;
  assign cmd_count = 16'd0;
`endif

endmodule

// File: tb/tb_jb_ul_oran_request_dispatch.sv
`timescale 1ns/1ps
module tb_jb_ul_oran_request_dispatch;

  localparam int MAX_BURST = 16;
  localparam int PRB_LIMIT = 273;
  localparam int LEN_W     = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             fifo_read;
  logic [23:0]      fifo_read_data = 24'd0;
  logic             fifo_empty = 1'b1;
  logic             cmd_valid;
  logic             cmd_ready = 1'b0;
  logic [2:0]       cmd_port;
  logic [3:0]       cmd_symbol;
  logic [8:0]       cmd_prb;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_last;
  logic             busy;
  logic             err_range;
  logic [15:0]      req_count;
  logic [15:0]      cmd_count;

  jb_ul_oran_request_dispatch #(
    .MAX_BURST(MAX_BURST), .PRB_LIMIT(PRB_LIMIT), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_read(fifo_read), .fifo_read_data(fifo_read_data), .fifo_empty(fifo_empty),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_port(cmd_port), .cmd_symbol(cmd_symbol), .cmd_prb(cmd_prb),
    .cmd_len(cmd_len), .cmd_last(cmd_last),
    .busy(busy), .err_range(err_range),
    .req_count(req_count), .cmd_count(cmd_count)
  );

  // ---------------- FIFO model (registered flags, async head read) ----------------
  logic [23:0] fifo_q[$];
  logic        push_en = 1'b0;
  logic [23:0] push_data = 24'd0;

  always @(posedge clk) begin
    if (fifo_read && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (push_en) fifo_q.push_back(push_data);
    fifo_empty     <= (fifo_q.size() == 0);
    fifo_read_data <= (fifo_q.size() > 0) ? fifo_q[0] : 24'd0;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [21:0] exp_q[$];          // {port, symbol, prb, len, last} still to be issued
  logic [14:0] hs_log[$];         // {prb, len, last} of transferred beats
  int          hs_cyc[$];
  logic [14:0] want_q[$];
  int n_checks = 0, n_errors = 0;
  int cyc = 0, err_seen = 0, rd_seen = 0;
  int req_m = 0, cmd_m = 0;
  bit err_pend = 1'b0;
  bit chk_en = 1'b0;
  bit exp_rd;
  int ready_mode = 1;             // 1 = high, 2 = low, 3 = random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit req_bad(input logic [23:0] w);
    int sym = int'(w[20:17]);
    int st  = int'(w[16:8]);
    int num = int'(w[7:0]);
    return (num == 0) || (sym > 13) || (st + num > PRB_LIMIT);
  endfunction

  // Split a request into MAX_BURST-sized beats.
  task automatic expand(input logic [23:0] w);
    int p = int'(w[16:8]);
    int r = int'(w[7:0]);
    int l;
    while (r > 0) begin
      l = (r < MAX_BURST) ? r : MAX_BURST;
      exp_q.push_back({w[23:21], w[20:17], p[8:0], l[LEN_W-1:0], (r <= MAX_BURST) ? 1'b1 : 1'b0});
      p += l;
      r -= l;
    end
  endtask

  // One compare process: sample on the falling edge, then advance the model
  // by what the next rising edge will do.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      cyc++;
      chk("cmd_valid", cmd_valid, exp_q.size() != 0);
      chk("busy", busy, exp_q.size() != 0);
      chk("err_range", err_range, err_pend);
      if (err_range) err_seen++;
      exp_rd = !fifo_empty && ((exp_q.size() == 0) || (cmd_ready && exp_q[0][0]));
      chk("fifo_read", fifo_read, exp_rd);
      if (fifo_read) begin
        rd_seen++;
        chk("underflow", fifo_empty, 0);
      end
`ifdef UL_ORAN_DISPATCH_STATS_EN
      chk("req_count", req_count, req_m);
      chk("cmd_count", cmd_count, cmd_m);
`else
      chk("req_count", req_count, 0);
      chk("cmd_count", cmd_count, 0);
`endif
      if (cmd_valid && exp_q.size() != 0)
        chk("beat", {cmd_port, cmd_symbol, cmd_prb, cmd_len, cmd_last}, exp_q[0]);
      err_pend = 1'b0;
      if (cmd_valid && cmd_ready && exp_q.size() != 0) begin
        hs_log.push_back({cmd_prb, cmd_len, cmd_last});
        hs_cyc.push_back(cyc);
        void'(exp_q.pop_front());
        if (cmd_m < 65535) cmd_m++;
      end
      if (fifo_read && !fifo_empty) begin
        if (req_bad(fifo_read_data)) err_pend = 1'b1;
        else begin
          expand(fifo_read_data);
          if (req_m < 65535) req_m++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clk);
      #3;
      cmd_ready = (ready_mode == 1) ? 1'b1 :
                  (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
    end
  end

  task automatic push_word(input logic [2:0] p, input logic [3:0] s,
                           input logic [8:0] st, input logic [7:0] n);
    @(posedge clk); #1;
    push_en   = 1'b1;
    push_data = {p, s, st, n};
    @(posedge clk); #1;
    push_en   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && fifo_empty && !push_en && !cmd_valid)) begin
      @(posedge clk); #2;
      n++;
      if (n > 3000) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name);
    chk({name, "_beats"}, hs_log.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < hs_log.size(); i++) chk(name, hs_log[i], want_q[i]);
  endtask

  task automatic check_counts(input string name, input int r, input int c);
`ifdef UL_ORAN_DISPATCH_STATS_EN
    chk({name, "_req"}, req_count, r);
    chk({name, "_cmd"}, cmd_count, c);
`else
    chk({name, "_req"}, req_count, 0);
    chk({name, "_cmd"}, cmd_count, 0);
`endif
  endtask

  task automatic wait_hs(input int n, input string name);
    int k = 0;
    while (hs_log.size() < n) begin
      @(posedge clk); #1;
      k++;
      if (k > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s_timeout: no transfer seen", name);
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  int e0, r0;
  logic [2:0] rp;
  logic [3:0] rs;
  logic [8:0] rst_prb;
  logic [7:0] rn;

  initial begin
    #3;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_range, 0);
    chk("rst_fields", {cmd_port, cmd_symbol, cmd_prb, cmd_len, cmd_last}, 0);
    chk("rst_counts", {req_count, cmd_count}, 0);
    chk("rst_read", fifo_read, 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    chk_en = 1'b1;

    // Single request split into three beats
    ready_mode = 1;
    hs_log.delete(); hs_cyc.delete();
    push_word(3'd2, 4'd5, 9'd0, 8'd40);
    wait_idle("single");
    want_q = '{{9'd0, 5'd16, 1'b0}, {9'd16, 5'd16, 1'b0}, {9'd32, 5'd8, 1'b1}};
    check_log("single");
    check_counts("single", 1, 3);

    // Back-to-back: second word popped on the last beat of the first
    ready_mode = 2;
    hs_log.delete(); hs_cyc.delete();
    push_word(3'd1, 4'd3, 9'd100, 8'd16);
    push_word(3'd1, 4'd3, 9'd200, 8'd1);
    repeat (2) @(posedge clk);
    #1 ready_mode = 1;
    wait_idle("b2b");
    want_q = '{{9'd100, 5'd16, 1'b1}, {9'd200, 5'd1, 1'b1}};
    check_log("b2b");
    if (hs_cyc.size() >= 2) chk("b2b_gap", hs_cyc[1] - hs_cyc[0], 1);

    // Range errors
    e0 = err_seen;
    hs_log.delete(); hs_cyc.delete();
    push_word(3'd0, 4'd0, 9'd10, 8'd0);
    push_word(3'd0, 4'd1, 9'd270, 8'd4);
    push_word(3'd0, 4'd14, 9'd0, 8'd1);
    wait_idle("range");
    chk("range_pulses", err_seen - e0, 3);
    want_q.delete();
    check_log("range");
    chk("range_drained", fifo_q.size(), 0);
    check_counts("range", 3, 5);

    // Backpressure for five cycles in the middle of a request
    hs_log.delete(); hs_cyc.delete();
    push_word(3'd6, 4'd7, 9'd10, 8'd40);
    wait_hs(1, "bp");
    ready_mode = 2;
    push_word(3'd5, 4'd2, 9'd0, 8'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold", {cmd_valid, cmd_prb, cmd_len, cmd_last}, {1'b1, 9'd26, 5'd16, 1'b0});
    chk("bp_no_pop", fifo_q.size(), 1);
    ready_mode = 1;
    wait_idle("bp");
    want_q = '{{9'd10, 5'd16, 1'b0}, {9'd26, 5'd16, 1'b0}, {9'd42, 5'd8, 1'b1}, {9'd0, 5'd1, 1'b1}};
    check_log("bp");

    // Upper PRB boundary, then an idle stretch with the FIFO empty
    hs_log.delete(); hs_cyc.delete();
    push_word(3'd7, 4'd13, 9'd257, 8'd16);
    wait_idle("edge");
    want_q = '{{9'd257, 5'd16, 1'b1}};
    check_log("edge");
    r0 = rd_seen;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_no_read", rd_seen - r0, 0);

    // Reset during beat 2 of 3; the queued word runs afterwards
    ready_mode = 2;
    push_word(3'd3, 4'd2, 9'd0, 8'd40);
    push_word(3'd4, 4'd1, 9'd50, 8'd5);
    hs_log.delete(); hs_cyc.delete();
    ready_mode = 1;
    wait_hs(1, "rst");
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", cmd_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_prb", cmd_prb, 0);
    exp_q.delete();
    err_pend = 1'b0;
    req_m = 0;
    cmd_m = 0;
    hs_log.delete(); hs_cyc.delete();
    #1 rst_n = 1'b1;
    wait_idle("rst");
    want_q = '{{9'd50, 5'd5, 1'b1}};
    check_log("rst");
    check_counts("rst", 1, 1);

    // Randomized traffic with random backpressure
    ready_mode = 3;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      while (fifo_q.size() >= 30) @(posedge clk);
      rp = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 13));
      rst_prb = 9'($urandom_range(0, 300));
      rn = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 80));
      push_word(rp, rs, rst_prb, rn);
    end
    wait_idle("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
